// File: rtl/thread_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : thread_queue_pkg
//  Description : Shared types and default sizes for the CICERO thread queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package thread_queue_pkg;

  localparam int c_default_pc_width   = 8;
  localparam int c_default_depth_log2 = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ADVANCE = 2'd1,
    DONE    = 2'd2
  } thread_queue_state_t;

endpackage
`default_nettype wire

// File: rtl/thread_queue_pc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fifo
//  Description : First-word-fall-through PC FIFO with registered storage.
//                The head is visible on pop_data whenever empty is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fifo
  import thread_queue_pkg::*;
#(
  parameter int PC_WIDTH   = c_default_pc_width,
  parameter int DEPTH_LOG2 = c_default_depth_log2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [PC_WIDTH-1:0] push_data,
  input  logic                pop,
  output logic [PC_WIDTH-1:0] pop_data,
  output logic                empty,
  output logic                full
);

  localparam int                c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(c_depth);

  logic [PC_WIDTH-1:0]   r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_full_count);
  assign pop_data  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; unread slots are never exposed past empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/thread_queue.sv
`default_nettype none
// ============================================================================
//  Module      : thread_queue
//  Description : Dual PC queue closing the loop around basic_block. Files PCs
//                into the current- or next-character queue, feeds current PCs
//                back, and swaps queues / pulses char_advance when the current
//                character is exhausted.
//                Optional feature macro: THREAD_QUEUE_DEDUP_EN drops a push to
//                the next queue that repeats the last PC stored there.
//  Revision    : 1.0 - initial release
// ============================================================================
module thread_queue
  import thread_queue_pkg::*;
#(
  parameter int PC_WIDTH   = c_default_pc_width,
  parameter int DEPTH_LOG2 = c_default_depth_log2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_pc_valid,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                in_pc_is_directed_to_current,
  output logic                in_pc_ready,
  output logic                out_pc_valid,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_pc_ready,
  input  logic                bb_idle,
  output logic                char_advance,
  output logic                no_threads
);

  thread_queue_state_t r_state;
  logic                r_sel;
  logic                r_char_advance;
  logic                r_no_threads;

  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [1:0]          w_empty;
  logic [1:0]          w_full;
  logic [PC_WIDTH-1:0] w_head [2];

  logic w_tgt;
  logic w_accept;
  logic w_drop;
  logic w_store;
  logic w_pop_any;
  logic w_cur_empty;
  logic w_nxt_empty;

  // Routing uses sel as it stands this cycle, including during ADVANCE.
  assign w_tgt       = in_pc_is_directed_to_current ? r_sel : ~r_sel;
  assign in_pc_ready = !w_full[w_tgt];
  assign w_accept    = in_pc_valid && in_pc_ready;
  assign w_store     = w_accept && !w_drop;

  assign w_cur_empty  = w_empty[r_sel];
  assign w_nxt_empty  = w_empty[~r_sel];
  assign out_pc_valid = (r_state == RUN) && !w_cur_empty;
  assign w_pop_any    = out_pc_valid && out_pc_ready;
  assign out_pc       = out_pc_valid ? w_head[r_sel] : '0;

  assign char_advance = r_char_advance;
  assign no_threads   = r_no_threads;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_queue
      assign w_push[i] = w_store && (w_tgt == 1'(i));
      assign w_pop[i]  = w_pop_any && (r_sel == 1'(i));

      pc_fifo #(
        .PC_WIDTH   (PC_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push[i]),
        .push_data (in_pc),
        .pop       (w_pop[i]),
        .pop_data  (w_head[i]),
        .empty     (w_empty[i]),
        .full      (w_full[i])
      );
    end
  endgenerate

`ifdef THREAD_QUEUE_DEDUP_EN
  logic                r_last_valid;
  logic [PC_WIDTH-1:0] r_last_pc;

  // A repeat of the last PC filed into the next queue is handshaken but not stored.
  assign w_drop = !in_pc_is_directed_to_current && r_last_valid && (in_pc == r_last_pc);

  // Track the last PC stored into the next queue; a swap forgets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_valid <= 1'b0;
      r_last_pc    <= '0;
    end else if (r_state == ADVANCE) begin
      r_last_valid <= 1'b0;
    end else if (w_store && !in_pc_is_directed_to_current) begin
      r_last_valid <= 1'b1;
      r_last_pc    <= in_pc;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  // Control FSM: swap queues when the current one drains, park when all is dry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_sel          <= 1'b0;
      r_char_advance <= 1'b0;
      r_no_threads   <= 1'b0;
    end else begin
      r_char_advance <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_cur_empty && bb_idle && !in_pc_valid) begin
            if (!w_nxt_empty) begin
              r_state        <= ADVANCE;
              r_char_advance <= 1'b1;
            end else begin
              r_state      <= DONE;
              r_no_threads <= 1'b1;
            end
          end
        end
        ADVANCE: begin
          r_sel   <= ~r_sel;
          r_state <= RUN;
        end
        DONE: begin
          if (w_accept) begin
            r_state      <= RUN;
            r_no_threads <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thread_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thread_queue
//  Description : Self-checking bench for thread_queue against a queue-level
//                reference model (directed steps followed by random traffic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_queue;

  logic       clk;
  logic       reset;
  logic       in_pc_valid;
  logic [7:0] in_pc;
  logic       in_pc_is_directed_to_current;
  logic       in_pc_ready;
  logic       out_pc_valid;
  logic [7:0] out_pc;
  logic       out_pc_ready;
  logic       bb_idle;
  logic       char_advance;
  logic       no_threads;

  thread_queue #(.PC_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .in_pc_valid                  (in_pc_valid),
    .in_pc                        (in_pc),
    .in_pc_is_directed_to_current (in_pc_is_directed_to_current),
    .in_pc_ready                  (in_pc_ready),
    .out_pc_valid                 (out_pc_valid),
    .out_pc                       (out_pc),
    .out_pc_ready                 (out_pc_ready),
    .bb_idle                      (bb_idle),
    .char_advance                 (char_advance),
    .no_threads                   (no_threads)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_seven = 0;

  // Reference model: two PC queues, the current-queue selector, and whether
  // the engine is in its one-cycle swap or parked with nothing left to do.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_sel;
  bit         m_adv;
  bit         m_done;
  int         m_last;

  function automatic int qsize(bit i);
    return i ? q1.size() : q0.size();
  endfunction

  function automatic logic [7:0] qhead(bit i);
    return i ? q1[0] : q0[0];
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_sel  = 1'b0;
    m_adv  = 1'b0;
    m_done = 1'b0;
    m_last = -1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model across the rising edge.
  task automatic cyc(input bit v, input bit [7:0] pc, input bit dir, input bit rdy, input bit idle);
    bit         tgt;
    bit         e_ready;
    bit         e_valid;
    logic [7:0] e_out;
    bit         acc;
    bit         pop;
    bit         drop;
    int         s_cur;
    int         s_nxt;
    in_pc_valid                  = v;
    in_pc                        = pc;
    in_pc_is_directed_to_current = dir;
    out_pc_ready                 = rdy;
    bb_idle                      = idle;
    @(negedge clk);
    tgt     = dir ? m_sel : !m_sel;
    e_ready = qsize(tgt) < 16;
    e_valid = !m_adv && !m_done && (qsize(m_sel) != 0);
    e_out   = e_valid ? qhead(m_sel) : 8'h00;
    chk("in_pc_ready", 32'(in_pc_ready), 32'(e_ready));
    chk("out_pc_valid", 32'(out_pc_valid), 32'(e_valid));
    chk("out_pc", 32'(out_pc), 32'(e_out));
    chk("char_advance", 32'(char_advance), 32'(m_adv));
    chk("no_threads", 32'(no_threads), 32'(m_done));
    if (out_pc_valid && out_pc_ready && out_pc == 8'h07) n_seven++;
    @(posedge clk);
    acc   = v && e_ready;
    pop   = e_valid && rdy;
    s_cur = qsize(m_sel);
    s_nxt = qsize(!m_sel);
    if (pop) begin
      if (m_sel) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (acc) begin
      drop = 1'b0;
`ifdef THREAD_QUEUE_DEDUP_EN
      if (tgt != m_sel && m_last == int'(pc)) drop = 1'b1;
`endif
      if (!drop) begin
        if (tgt) q1.push_back(pc); else q0.push_back(pc);
        if (tgt != m_sel) m_last = int'(pc);
      end
    end
    if (m_adv) begin
      m_adv  = 1'b0;
      m_sel  = !m_sel;
      m_last = -1;
    end else if (m_done) begin
      if (acc) m_done = 1'b0;
    end else if (s_cur == 0 && idle && !v) begin
      if (s_nxt != 0) m_adv = 1'b1;
      else            m_done = 1'b1;
    end
    #1;
  endtask

  initial begin
    int exp_sevens;
    reset                        = 1'b0;
    in_pc_valid                  = 1'b0;
    in_pc                        = 8'h00;
    in_pc_is_directed_to_current = 1'b0;
    out_pc_ready                 = 1'b0;
    bb_idle                      = 1'b0;
    model_reset();

    // Reset values
    #2;
    chk("rst_in_pc_ready", 32'(in_pc_ready), 32'd1);
    chk("rst_out_pc_valid", 32'(out_pc_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_char_advance", 32'(char_advance), 32'd0);
    chk("rst_no_threads", 32'(no_threads), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Push 00 to current, see it next cycle, pop it; bb busy keeps no_threads low
    cyc(1, 8'h00, 1, 0, 0);
    chk("first_out_valid", 32'(out_pc_valid), 32'd1);
    chk("first_out_pc", 32'(out_pc), 32'h00);
    cyc(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 1, 0);

    // Push CC to next, bb idle: one char_advance pulse then CC delivered
    cyc(1, 8'hCC, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0);

    // Fill current with 10..1F
    for (int i = 0; i < 16; i++) cyc(1, 8'h10 + 8'(i), 1, 0, 0);
    in_pc_valid                  = 1'b0;
    in_pc_is_directed_to_current = 1'b1;
    #1;
    chk("full_cur_ready", 32'(in_pc_ready), 32'd0);
    in_pc_is_directed_to_current = 1'b0;
    #1;
    chk("full_nxt_ready", 32'(in_pc_ready), 32'd1);

    // Pop head while offering 42 to the full current queue: refused
    cyc(1, 8'h42, 1, 1, 0);
    for (int i = 0; i < 17; i++) cyc(0, 8'h00, 1, 1, 0);

    // Both empty, bb idle: no_threads rises with no swap; push 05 to next clears it
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 1);
    chk("dry_no_threads", 32'(no_threads), 32'd1);
    chk("dry_char_advance", 32'(char_advance), 32'd0);
    cyc(1, 8'h05, 0, 0, 1);
    chk("nt_cleared", 32'(no_threads), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 1, 1);

    // Duplicate 07 pushes to next, then swap and count deliveries
    n_seven = 0;
    cyc(1, 8'h07, 0, 0, 0);
    cyc(1, 8'h07, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 0, 1, 1);
`ifdef THREAD_QUEUE_DEDUP_EN
    exp_sevens = 1;
`else
    exp_sevens = 2;
`endif
    chk("dup_07_count", 32'(n_seven), 32'(exp_sevens));

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Reset asserted mid-operation
    for (int i = 0; i < 6; i++) cyc(1, 8'($urandom_range(0, 255)), 1'(i % 2), 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_pc_valid", 32'(out_pc_valid), 32'd0);
    chk("mid_rst_out_pc", 32'(out_pc), 32'd0);
    chk("mid_rst_in_pc_ready", 32'(in_pc_ready), 32'd1);
    chk("mid_rst_char_advance", 32'(char_advance), 32'd0);
    chk("mid_rst_no_threads", 32'(no_threads), 32'd0);
    model_reset();
    in_pc_valid = 1'b0;
    bb_idle     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
